k2_control_unit: RTL and testbench

K2_CONTROL_UNIT -- requirements
Module: k2_control_unit

---
 rtl/k2_ctrl_pkg.sv | 27 ++
 rtl/k2_pc.sv | 28 ++
 rtl/k2_control_unit.sv | 130 +++++++++++++
 tb/tb_k2_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/k2_ctrl_pkg.sv
// Shared types for the K2 control unit: FSM states, opcodes and the default
// program-counter width.
package k2_ctrl_pkg;

  localparam int unsigned K2_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FLAGS  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_OUT  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'h9
  } opcode_t;

endpackage

// File: rtl/k2_pc.sv
// Program counter: synchronous active-high reset, increment, and parallel
// load; a load wins over an increment in the same cycle.
module k2_pc #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/k2_control_unit.sv
// K2 control unit: fetch/execute/flags/halt sequencer driving register
// enables and ALU select for a small 4-bit accumulator datapath.
module k2_control_unit
  import k2_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = K2_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        instr,
  input  logic              c,
  input  logic              z,
  output logic [ADDR_W-1:0] pc,
  output logic              alu_s,
  output logic              ra_en,
  output logic              rb_en,
  output logic              ro_en,
  output logic              ra_src,
  output logic [3:0]        imm,
  output logic              halted,
  output logic              illegal
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_ir;
  logic       r_cf;
  logic       r_zf;

  logic [3:0] w_op;
  logic       w_pc_inc;
  logic       w_pc_load;
  logic       w_alu_s;
  logic       w_ra_en;
  logic       w_rb_en;
  logic       w_ro_en;
  logic       w_ra_src;
  logic       w_illegal;

  assign w_op = r_ir[7:4];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_alu_s     = 1'b0;
    w_ra_en     = 1'b0;
    w_rb_en     = 1'b0;
    w_ro_en     = 1'b0;
    w_ra_src    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (run) begin
          w_pc_inc    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        case (w_op)
          OP_NOP:  ;
          OP_LDA:  w_ra_en = 1'b1;
          OP_LDB:  w_rb_en = 1'b1;
          OP_ADD: begin
            w_ra_en     = 1'b1;
            w_ra_src    = 1'b1;
            w_state_nxt = ST_FLAGS;
          end
          OP_SUB: begin
            w_ra_en     = 1'b1;
            w_ra_src    = 1'b1;
            w_alu_s     = 1'b1;
            w_state_nxt = ST_FLAGS;
          end
          OP_OUT:  w_ro_en   = 1'b1;
          OP_JMP:  w_pc_load = 1'b1;
          OP_JC:   w_pc_load = r_cf;
          OP_JZ:   w_pc_load = r_zf;
          OP_HALT: w_state_nxt = ST_HALTED;
          default: w_illegal = 1'b1;
        endcase
      end
      ST_FLAGS:  w_state_nxt = ST_FETCH;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && run) begin
        r_ir <= instr;
      end
      if (r_state == ST_FLAGS) begin
        r_cf <= c;
        r_zf <= z;
      end
    end
  end

  k2_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_pc_inc),
    .load     (w_pc_load),
    .load_val (r_ir[ADDR_W-1:0]),
    .pc       (pc)
  );

  // Outputs are masked by rst so a reset landing in EXEC issues no partial enable.
  assign alu_s   = w_alu_s   & ~rst;
  assign ra_en   = w_ra_en   & ~rst;
  assign rb_en   = w_rb_en   & ~rst;
  assign ro_en   = w_ro_en   & ~rst;
  assign ra_src  = w_ra_src  & ~rst;
  assign illegal = w_illegal & ~rst;
  assign halted  = (r_state == ST_HALTED) & ~rst;
  assign imm     = r_ir[3:0];

endmodule

// File: tb/tb_k2_control_unit.sv
// Directed bench for k2_control_unit with a small ROM and a 4-bit ALU/register
// environment feeding back registered carry/zero.
module tb_k2_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b1;
  logic [7:0] instr;
  logic       c, z;
  logic [3:0] pc;
  logic       alu_s, ra_en, rb_en, ro_en, ra_src, halted, illegal;
  logic [3:0] imm;

  logic [7:0] rom [16];
  logic [3:0] ra, rb, ro;
  logic [4:0] alu;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  k2_control_unit #(.ADDR_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .instr   (instr),
    .c       (c),
    .z       (z),
    .pc      (pc),
    .alu_s   (alu_s),
    .ra_en   (ra_en),
    .rb_en   (rb_en),
    .ro_en   (ro_en),
    .ra_src  (ra_src),
    .imm     (imm),
    .halted  (halted),
    .illegal (illegal)
  );

  assign instr = rom[pc];
  assign alu = alu_s ? ({1'b0, ra} + {1'b0, ~rb} + 5'd1) : ({1'b0, ra} + {1'b0, rb});

  always @(posedge clk) begin
    if (rst) begin
      ra <= '0; rb <= '0; ro <= '0; c <= 1'b0; z <= 1'b0;
    end else begin
      if (ra_en) ra <= ra_src ? alu[3:0] : imm;
      if (ra_en && ra_src) begin
        c <= alu[4];
        z <= (alu[3:0] == 4'd0);
      end
      if (rb_en) rb <= imm;
      if (ro_en) ro <= ra;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load_rom(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3,
                          input logic [7:0] p4);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3; rom[4] = p4;
  endtask

  task automatic do_reset();
    run = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cyc = 0;
  endtask

  function automatic logic [3:0] enables();
    return {ra_en, rb_en, ro_en, illegal};
  endfunction

  initial begin
    int bad;

    // LDA 5; LDB 3; ADD; OUT; HALT
    load_rom(8'h15, 8'h23, 8'h30, 8'h50, 8'h90);
    rst = 1'b1;
    tick();
    chk("rst_enables", {28'd0, enables()}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'h0);
    rst = 1'b0;
    #1;
    cyc = 0;
    chk("rst_pc", {28'd0, pc}, 32'h0);
    chk("rst_imm", {28'd0, imm}, 32'h0);
    chk("rst_cfzf", {30'd0, dut.r_cf, dut.r_zf}, 32'h0);
    chk("post_rst_enables", {28'd0, enables()}, 32'h0);
    tick();
    chk("lda_exec", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b10000);
    chk("lda_imm", {28'd0, imm}, 32'h5);
    tick(2);
    chk("ldb_exec", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b00100);
    tick(2);
    chk("add_exec", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b11000);
    tick();
    chk("flags_quiet", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b00000);
    tick();
    chk("add_ra", {28'd0, ra}, 32'h8);
    chk("add_flags", {30'd0, dut.r_cf, dut.r_zf}, 32'h0);
    chk("add_pc", {28'd0, pc}, 32'h3);
    tick();
    chk("out_cycle", cyc, 32'd8);
    chk("out_exec", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b00010);
    tick();
    chk("out_ro", {28'd0, ro}, 32'h8);
    tick(2);
    chk("halt_halted", {31'd0, halted}, 32'h1);
    chk("halt_pc", {28'd0, pc}, 32'h5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
      if (pc !== 4'h5 || halted !== 1'b1 || enables() !== 4'h0) bad++;
    end
    run = 1'b1;
    chk("halt_hold", bad, 0);

    // LDA 3; LDB 3; SUB; JZ A
    load_rom(8'h13, 8'h23, 8'h40, 8'h8A, 8'h00);
    do_reset();
    tick(5);
    chk("sub_exec", {27'd0, ra_en, ra_src, rb_en, ro_en, alu_s}, 32'b11001);
    tick(2);
    chk("sub_zf", {31'd0, dut.r_zf}, 32'h1);
    chk("sub_ra", {28'd0, ra}, 32'h0);
    tick(2);
    chk("jz_taken_pc", {28'd0, pc}, 32'hA);

    // LDA 4; LDB 3; SUB; JZ A -> no jump
    load_rom(8'h14, 8'h23, 8'h40, 8'h8A, 8'h00);
    do_reset();
    tick(9);
    chk("jz_not_taken_zf", {31'd0, dut.r_zf}, 32'h0);
    chk("jz_not_taken_pc", {28'd0, pc}, 32'h4);

    // LDA F; LDB 1; ADD; JC 0; then NOPs wrap the pc
    load_rom(8'h1F, 8'h21, 8'h30, 8'h70, 8'h00);
    do_reset();
    tick(9);
    chk("jc_cf", {31'd0, dut.r_cf}, 32'h1);
    chk("jc_pc", {28'd0, pc}, 32'h0);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    tick(30);
    chk("wrap_pc_f", {28'd0, pc}, 32'hF);
    tick(2);
    chk("wrap_pc_0", {28'd0, pc}, 32'h0);
    chk("wrap_cf_held", {31'd0, dut.r_cf}, 32'h1);

    // Illegal opcode then NOP
    load_rom(8'hB0, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    tick();
    chk("illegal_pulse", {27'd0, illegal, ra_en, rb_en, ro_en, ra_src}, 32'b10000);
    tick();
    chk("illegal_one_cycle", {31'd0, illegal}, 32'h0);
    chk("illegal_next_pc", {28'd0, pc}, 32'h1);

    // Self-jump loops without halting
    load_rom(8'h60, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    tick(10);
    chk("selfjmp_pc", {28'd0, pc}, 32'h0);
    chk("selfjmp_not_halted", {31'd0, halted}, 32'h0);

    // run=0 stalls in FETCH
    load_rom(8'h15, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    run = 1'b0;
    tick(5);
    chk("stall_pc", {28'd0, pc}, 32'h0);
    chk("stall_ir", {24'd0, dut.r_ir}, 32'h0);
    run = 1'b1;
    tick();
    chk("stall_resume", {31'd0, ra_en}, 32'h1);

    // Reset during ADD EXEC
    load_rom(8'h1F, 8'h21, 8'h30, 8'h00, 8'h00);
    do_reset();
    tick(5);
    chk("pre_abort_ra_en", {31'd0, ra_en}, 32'h1);
    rst = 1'b1;
    run = 1'b1;
    #1;
    chk("abort_ra_en", {31'd0, ra_en}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_pc", {28'd0, pc}, 32'h0);
    chk("abort_cfzf", {30'd0, dut.r_cf, dut.r_zf}, 32'h0);
    chk("abort_ra", {28'd0, ra}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
